uart_tx_buffer: RTL

Byte-stream front end for the UART transmitter. It accepts bytes on a valid/ready interface, holds them in an internal FIFO, and issues them one at a time on the transmitter's `tx_data`/`tx_new_data` strobe interface, pacing each byte on `tx_busy`. It sits between any byte producer (command encoder, debug logger) and the `tx_*` ports of the UART top, so producers can burst without polling `tx_busy`.

---
 rtl/uart_pkg.sv | 12 +
 rtl/uart_tx_buffer_if.sv | 24 ++
 rtl/uart_sync_fifo.sv | 74 +++++++
 rtl/uart_tx_buffer.sv | 107 ++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants for the UART transmit-side byte buffer.
package uart_pkg;

    localparam int unsigned UART_DATA_W      = 8;
    localparam int unsigned UART_TXB_STATE_W = 2;
    localparam int unsigned UART_TXB_CNT_W   = 8;

    localparam logic [UART_TXB_STATE_W-1:0] UART_TXB_IDLE      = 2'd0;
    localparam logic [UART_TXB_STATE_W-1:0] UART_TXB_WAIT_BUSY = 2'd1;
    localparam logic [UART_TXB_STATE_W-1:0] UART_TXB_WAIT_DONE = 2'd2;

endpackage

// File: rtl/uart_tx_buffer_if.sv
// Producer-side valid/ready byte stream plus the UART transmitter strobe port.
interface uart_tx_buffer_if;
    import uart_pkg::*;

    logic [UART_DATA_W-1:0] s_data;
    logic                   s_valid;
    logic                   s_ready;
    logic [UART_DATA_W-1:0] tx_data;
    logic                   tx_new_data;
    logic                   tx_busy;

    // Buffer side: consumes the byte stream, drives the transmitter.
    modport slave (
        input  s_data, s_valid, tx_busy,
        output s_ready, tx_data, tx_new_data
    );

    // Environment side: producer and UART transmitter.
    modport master (
        output s_data, s_valid, tx_busy,
        input  s_ready, tx_data, tx_new_data
    );

endinterface

// File: rtl/uart_sync_fifo.sv
// Single-clock show-ahead FIFO with registered level/full/empty and flush.
module uart_sync_fifo #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  push,
    input  logic                  pop,
    input  logic [WIDTH-1:0]      wr_data,
    output logic [WIDTH-1:0]      rd_data_c,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  empty,
    output logic                  full,
    output logic                  full_next_c
);

    localparam int unsigned DEPTH   = 1 << DEPTH_LOG2;
    localparam int unsigned LEVEL_W = DEPTH_LOG2 + 1;

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  do_push_c;
    logic                  do_pop_c;
    logic [LEVEL_W-1:0]    level_next_c;

    // Qualify requests and compute next occupancy; flush drops a same-cycle write.
    always_comb begin
        do_push_c    = push && !full && !flush;
        do_pop_c     = pop && !empty;
        level_next_c = level;
        if (flush) begin
            level_next_c = '0;
        end else begin
            case ({do_push_c, do_pop_c})
                2'b10:   level_next_c = level + LEVEL_W'(1);
                2'b01:   level_next_c = level - LEVEL_W'(1);
                default: level_next_c = level;
            endcase
        end
        full_next_c = (level_next_c == LEVEL_W'(DEPTH));
        rd_data_c   = mem[rd_ptr];
    end

    // Pointers and status flags.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (do_push_c) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
                if (do_pop_c)  rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
            end
            level <= level_next_c;
            empty <= (level_next_c == '0);
            full  <= full_next_c;
        end
    end

    // Storage array; contents are don't-care once the pointers are cleared.
    always_ff @(posedge clock) begin
        if (do_push_c) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/uart_tx_buffer.sv
// Buffers producer bytes and launches them one at a time into the UART transmitter.
module uart_tx_buffer
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2   = 4,
    parameter int unsigned BUSY_TIMEOUT = 15
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                flush,
    uart_tx_buffer_if.slave     bus,
    output logic [DEPTH_LOG2:0] level,
    output logic                empty,
    output logic                full,
    output logic                tx_timeout
);

    logic [UART_TXB_STATE_W-1:0] state;
    logic [UART_TXB_STATE_W-1:0] state_next;
    logic [UART_TXB_CNT_W-1:0]   cnt;
    logic [UART_TXB_CNT_W-1:0]   cnt_next;
    logic [UART_DATA_W-1:0]      head_c;
    logic [UART_DATA_W-1:0]      tx_data_next;
    logic                        tx_new_data_next;
    logic                        tx_timeout_next;
    logic                        push_c;
    logic                        pop_c;
    logic                        full_next_c;

    // A byte is accepted only while the registered ready is high.
    always_comb begin
        push_c = bus.s_valid && bus.s_ready;
    end

    uart_sync_fifo #(
        .WIDTH      (UART_DATA_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clock       (clock),
        .reset       (reset),
        .flush       (flush),
        .push        (push_c),
        .pop         (pop_c),
        .wr_data     (bus.s_data),
        .rd_data_c   (head_c),
        .level       (level),
        .empty       (empty),
        .full        (full),
        .full_next_c (full_next_c)
    );

    // Launch/pacing FSM: strobe a byte, wait for busy to rise, then to fall.
    always_comb begin
        state_next       = state;
        cnt_next         = cnt;
        pop_c            = 1'b0;
        tx_data_next     = bus.tx_data;
        tx_new_data_next = 1'b0;
        tx_timeout_next  = 1'b0;
        case (state)
            UART_TXB_IDLE: begin
                if (!empty && !bus.tx_busy) begin
                    pop_c            = 1'b1;
                    tx_data_next     = head_c;
                    tx_new_data_next = 1'b1;
                    cnt_next         = '0;
                    state_next       = UART_TXB_WAIT_BUSY;
                end
            end
            UART_TXB_WAIT_BUSY: begin
                if (bus.tx_busy) begin
                    state_next = UART_TXB_WAIT_DONE;
                end else if (cnt == UART_TXB_CNT_W'(BUSY_TIMEOUT)) begin
                    // Transmitter never acknowledged; the byte is dropped.
                    tx_timeout_next = 1'b1;
                    state_next      = UART_TXB_IDLE;
                end else begin
                    cnt_next = cnt + UART_TXB_CNT_W'(1);
                end
            end
            UART_TXB_WAIT_DONE: begin
                if (!bus.tx_busy) state_next = UART_TXB_IDLE;
            end
            default: state_next = UART_TXB_IDLE;
        endcase
    end

    // State, timeout counter and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state           <= UART_TXB_IDLE;
            cnt             <= '0;
            bus.s_ready     <= 1'b0;
            bus.tx_data     <= '0;
            bus.tx_new_data <= 1'b0;
            tx_timeout      <= 1'b0;
        end else begin
            state           <= state_next;
            cnt             <= cnt_next;
            bus.s_ready     <= !full_next_c;
            bus.tx_data     <= tx_data_next;
            bus.tx_new_data <= tx_new_data_next;
            tx_timeout      <= tx_timeout_next;
        end
    end

endmodule
